// File: rtl/aes_word_block_adapter.sv
// aes_word_block_adapter
// Bridges 32-bit HWPE word streams and the 128-bit AES core interface.
// The pack path gathers four plaintext words into one block; the unpack
// path splits each ciphertext block back into four words. The two paths
// run independently and share only the synchronous clear and idle status.
module aes_word_block_adapter #(
    parameter bit MSB_FIRST = 1'b1,
    parameter int CNT_W     = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clear,
    // plaintext word stream in
    input  logic [31:0]        in_data_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    // plaintext block to the core
    output logic [127:0]       blk_data_o,
    output logic               blk_valid_o,
    input  logic               blk_ready_i,
    // ciphertext block from the core
    input  logic [127:0]       res_data_i,
    input  logic               res_valid_i,
    output logic               res_ready_o,
    // ciphertext word stream out
    output logic [31:0]        out_data_o,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    // status
    output logic [1:0]         pk_cnt_o,
    output logic [CNT_W-1:0]   blocks_packed_o,
    output logic [CNT_W-1:0]   blocks_unpacked_o,
    output logic               idle_o
);

    typedef enum logic {
        PK_FILL = 1'b0,
        PK_FULL = 1'b1
    } pk_state_t;

    typedef enum logic {
        UP_EMPTY = 1'b0,
        UP_DRAIN = 1'b1
    } up_state_t;

    // Bit offset of word slot idx inside a 128-bit block. With MSB_FIRST
    // word 0 lands in the top lane, so the lane number is simply ~idx.
    function automatic logic [6:0] slot_lsb(input logic [1:0] idx);
        logic [1:0] lane;
        lane = MSB_FIRST ? ~idx : idx;
        return {lane, 5'b0_0000};
    endfunction

    pk_state_t          r_pk_state;
    logic [1:0]         r_pk_cnt;
    logic [127:0]       r_blk;
    logic [CNT_W-1:0]   r_blocks_packed;

    up_state_t          r_up_state;
    logic [1:0]         r_up_idx;
    logic [127:0]       r_res;
    logic [CNT_W-1:0]   r_blocks_unpacked;

    logic [6:0]         w_pk_off;
    logic [6:0]         w_up_off;
    logic               w_in_hs;
    logic               w_blk_hs;
    logic               w_res_hs;
    logic               w_out_hs;

    assign w_pk_off = slot_lsb(r_pk_cnt);
    assign w_up_off = slot_lsb(r_up_idx);

    // Ready/valid are pure state decodes, so handshakes never form a
    // combinational path from input valid to output ready.
    assign in_ready_o  = (r_pk_state == PK_FILL);
    assign blk_valid_o = (r_pk_state == PK_FULL);
    assign res_ready_o = (r_up_state == UP_EMPTY);
    assign out_valid_o = (r_up_state == UP_DRAIN);

    assign w_in_hs  = in_valid_i  & in_ready_o;
    assign w_blk_hs = blk_valid_o & blk_ready_i;
    assign w_res_hs = res_valid_i & res_ready_o;
    assign w_out_hs = out_valid_o & out_ready_i;

    // Pack FSM: fill four slots, then hold the block until the core takes it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pk_state      <= PK_FILL;
            r_pk_cnt        <= 2'd0;
            r_blk           <= '0;
            r_blocks_packed <= '0;
        end else if (clear) begin
            r_pk_state      <= PK_FILL;
            r_pk_cnt        <= 2'd0;
            r_blk           <= '0;
            r_blocks_packed <= '0;
        end else if (r_pk_state == PK_FILL) begin
            if (w_in_hs) begin
                r_blk[w_pk_off +: 32] <= in_data_i;
                r_pk_cnt              <= r_pk_cnt + 2'd1;
                if (r_pk_cnt == 2'd3) begin
                    r_pk_state <= PK_FULL;
                end
            end
        end else begin
            if (w_blk_hs) begin
                r_blocks_packed <= r_blocks_packed + CNT_W'(1);
                r_pk_state      <= PK_FILL;
            end
        end
    end

    // Unpack FSM: capture a block, then emit its four words in slot order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_up_state        <= UP_EMPTY;
            r_up_idx          <= 2'd0;
            r_res             <= '0;
            r_blocks_unpacked <= '0;
        end else if (clear) begin
            r_up_state        <= UP_EMPTY;
            r_up_idx          <= 2'd0;
            r_res             <= '0;
            r_blocks_unpacked <= '0;
        end else if (r_up_state == UP_EMPTY) begin
            if (w_res_hs) begin
                r_res      <= res_data_i;
                r_up_idx   <= 2'd0;
                r_up_state <= UP_DRAIN;
            end
        end else begin
            if (w_out_hs) begin
                r_up_idx <= r_up_idx + 2'd1;
                if (r_up_idx == 2'd3) begin
                    r_blocks_unpacked <= r_blocks_unpacked + CNT_W'(1);
                    r_up_state        <= UP_EMPTY;
                end
            end
        end
    end

    assign blk_data_o        = r_blk;
    assign out_data_o        = r_res[w_up_off +: 32];
    assign pk_cnt_o          = r_pk_cnt;
    assign blocks_packed_o   = r_blocks_packed;
    assign blocks_unpacked_o = r_blocks_unpacked;
    assign idle_o            = (r_pk_state == PK_FILL) && (r_pk_cnt == 2'd0)
                               && (r_up_state == UP_EMPTY);

endmodule

// File: tb/tb_aes_word_block_adapter.sv
// Testbench for aes_word_block_adapter: drives one MSB_FIRST=1 and one
// MSB_FIRST=0 instance with identical stimulus and checks both word orders.
module tb_aes_word_block_adapter;

    logic         clk;
    logic         reset_n;
    logic         clear;
    logic [31:0]  in_data_i;
    logic         in_valid_i;
    logic         blk_ready_i;
    logic [127:0] res_data_i;
    logic         res_valid_i;
    logic         out_ready_i;

    logic         in_ready, blk_valid, res_ready, out_valid, idle;
    logic [127:0] blk_data;
    logic [31:0]  out_data;
    logic [1:0]   pk_cnt;
    logic [7:0]   bpk, bup;

    logic         in_ready_l, blk_valid_l, res_ready_l, out_valid_l, idle_l;
    logic [127:0] blk_data_l;
    logic [31:0]  out_data_l;
    logic [1:0]   pk_cnt_l;
    logic [7:0]   bpk_l, bup_l;

    int checks;
    int errors;

    aes_word_block_adapter #(.MSB_FIRST(1'b1), .CNT_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .clear(clear),
        .in_data_i(in_data_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready),
        .blk_data_o(blk_data), .blk_valid_o(blk_valid), .blk_ready_i(blk_ready_i),
        .res_data_i(res_data_i), .res_valid_i(res_valid_i), .res_ready_o(res_ready),
        .out_data_o(out_data), .out_valid_o(out_valid), .out_ready_i(out_ready_i),
        .pk_cnt_o(pk_cnt), .blocks_packed_o(bpk), .blocks_unpacked_o(bup),
        .idle_o(idle)
    );

    aes_word_block_adapter #(.MSB_FIRST(1'b0), .CNT_W(8)) dut_lsb (
        .clk(clk), .reset_n(reset_n), .clear(clear),
        .in_data_i(in_data_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_l),
        .blk_data_o(blk_data_l), .blk_valid_o(blk_valid_l), .blk_ready_i(blk_ready_i),
        .res_data_i(res_data_i), .res_valid_i(res_valid_i), .res_ready_o(res_ready_l),
        .out_data_o(out_data_l), .out_valid_o(out_valid_l), .out_ready_i(out_ready_i),
        .pk_cnt_o(pk_cnt_l), .blocks_packed_o(bpk_l), .blocks_unpacked_o(bup_l),
        .idle_o(idle_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] pword(input int n);
        logic [31:0] v;
        v = 32'(n);
        return (v * 32'h9E3779B9) ^ 32'h5A5A0000;
    endfunction

    function automatic logic [31:0] rword(input int n);
        logic [31:0] v;
        v = 32'(n);
        return (v * 32'h7F4A7C15) ^ 32'h00C3_3C00;
    endfunction

    task automatic test_reset;
        reset_n = 1'b0; clear = 1'b0;
        in_data_i = '0; in_valid_i = 1'b0; blk_ready_i = 1'b0;
        res_data_i = '0; res_valid_i = 1'b0; out_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || res_ready !== 1'b1 || blk_valid !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_handshake: in_ready=%b res_ready=%b blk_valid=%b out_valid=%b, required 1 1 0 0",
                     in_ready, res_ready, blk_valid, out_valid);
        end
        checks++;
        if (idle !== 1'b1 || pk_cnt !== 2'd0 || bpk !== 8'd0 || bup !== 8'd0 || blk_data !== 128'd0 || out_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: idle=%b pk_cnt=%0d bpk=%0d bup=%0d blk=%h out=%h, required 1 0 0 0 0 0",
                     idle, pk_cnt, bpk, bup, blk_data, out_data);
        end
        reset_n = 1'b1;
        tick();
        checks++;
        if (idle !== 1'b1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: idle=%b in_ready=%b, required 1 1", idle, in_ready);
        end
    endtask

    task automatic test_pack;
        logic [31:0] w [4];
        w[0] = 32'h00112233; w[1] = 32'h44556677; w[2] = 32'h8899AABB; w[3] = 32'hCCDDEEFF;
        blk_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid_i = 1'b1;
            in_data_i  = w[i];
            checks++;
            if (in_ready !== 1'b1 || blk_valid !== 1'b0) begin
                errors++;
                $display("FAIL pack_fill_%0d: in_ready=%b blk_valid=%b, required 1 0", i, in_ready, blk_valid);
            end
            tick();
        end
        in_valid_i = 1'b0;
        checks++;
        if (blk_valid !== 1'b1 || in_ready !== 1'b0 || bpk !== 8'd0) begin
            errors++;
            $display("FAIL pack_valid_cycle: blk_valid=%b in_ready=%b bpk=%0d, required 1 0 0", blk_valid, in_ready, bpk);
        end
        checks++;
        if (blk_data !== 128'h00112233_44556677_8899AABB_CCDDEEFF) begin
            errors++;
            $display("FAIL pack_msb_data: got %h, required %h", blk_data, 128'h00112233_44556677_8899AABB_CCDDEEFF);
        end
        checks++;
        if (blk_data_l !== 128'hCCDDEEFF_8899AABB_44556677_00112233) begin
            errors++;
            $display("FAIL pack_lsb_data: got %h, required %h", blk_data_l, 128'hCCDDEEFF_8899AABB_44556677_00112233);
        end
        tick();
        checks++;
        if (blk_valid !== 1'b0 || in_ready !== 1'b1 || bpk !== 8'd1 || pk_cnt !== 2'd0 || idle !== 1'b1) begin
            errors++;
            $display("FAIL pack_taken: blk_valid=%b in_ready=%b bpk=%0d pk_cnt=%0d idle=%b, required 0 1 1 0 1",
                     blk_valid, in_ready, bpk, pk_cnt, idle);
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] w [4];
        w[0] = 32'hA0A0A0A0; w[1] = 32'hA1A1A1A1; w[2] = 32'hA2A2A2A2; w[3] = 32'hA3A3A3A3;
        blk_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid_i = 1'b1;
            in_data_i  = w[i];
            tick();
        end
        in_data_i = 32'hDEADBEEF;
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (blk_valid !== 1'b1 || in_ready !== 1'b0 || pk_cnt !== 2'd0 ||
                blk_data !== 128'hA0A0A0A0_A1A1A1A1_A2A2A2A2_A3A3A3A3) begin
                errors++;
                $display("FAIL backpressure_hold_%0d: blk_valid=%b in_ready=%b pk_cnt=%0d blk=%h, required 1 0 0 a0a0a0a0a1a1a1a1a2a2a2a2a3a3a3a3",
                         c, blk_valid, in_ready, pk_cnt, blk_data);
            end
            tick();
        end
        in_valid_i  = 1'b0;
        blk_ready_i = 1'b1;
        tick();
        checks++;
        if (bpk !== 8'd2 || blk_valid !== 1'b0 || pk_cnt !== 2'd0) begin
            errors++;
            $display("FAIL backpressure_release: bpk=%0d blk_valid=%b pk_cnt=%0d, required 2 0 0", bpk, blk_valid, pk_cnt);
        end
    endtask

    task automatic test_unpack;
        logic [31:0] e [4];
        int k;
        e[0] = 32'h01234567; e[1] = 32'h89ABCDEF; e[2] = 32'hFEDCBA98; e[3] = 32'h76543210;
        res_data_i  = 128'h0123456789ABCDEF_FEDCBA9876543210;
        res_valid_i = 1'b1;
        checks++;
        if (res_ready !== 1'b1) begin
            errors++;
            $display("FAIL unpack_accept: res_ready=%b, required 1", res_ready);
        end
        tick();
        res_valid_i = 1'b0;
        k = 0;
        for (int c = 0; c < 20 && k < 4; c++) begin
            out_ready_i = (c % 2 == 1);
            checks++;
            if (out_valid !== 1'b1 || res_ready !== 1'b0 || out_data !== e[k] || out_data_l !== e[3-k]) begin
                errors++;
                $display("FAIL unpack_word_%0d: out_valid=%b res_ready=%b msb=%h lsb=%h, required 1 0 %h %h",
                         k, out_valid, res_ready, out_data, out_data_l, e[k], e[3-k]);
            end
            if (out_ready_i) k++;
            tick();
        end
        out_ready_i = 1'b0;
        checks++;
        if (k != 4 || res_ready !== 1'b1 || out_valid !== 1'b0 || bup !== 8'd1) begin
            errors++;
            $display("FAIL unpack_done: words=%0d res_ready=%b out_valid=%b bup=%0d, required 4 1 0 1",
                     k, res_ready, out_valid, bup);
        end
    endtask

    task automatic test_clear;
        logic [31:0] w [4];
        w[0] = 32'h10101010; w[1] = 32'h20202020; w[2] = 32'h30303030; w[3] = 32'h40404040;
        blk_ready_i = 1'b1;
        in_valid_i = 1'b1; in_data_i = 32'hBAD00001; tick();
        in_data_i = 32'hBAD00002; tick();
        in_valid_i = 1'b0;
        res_data_i = {4{32'hC1EA4C1E}}; res_valid_i = 1'b1; tick();
        res_valid_i = 1'b0;
        checks++;
        if (pk_cnt !== 2'd2 || idle !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL clear_setup: pk_cnt=%0d idle=%b out_valid=%b, required 2 0 1", pk_cnt, idle, out_valid);
        end
        in_valid_i = 1'b1; in_data_i = 32'hBAD00003; out_ready_i = 1'b1; clear = 1'b1;
        tick();
        clear = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
        checks++;
        if (pk_cnt !== 2'd0 || idle !== 1'b1 || in_ready !== 1'b1 || res_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL clear_state: pk_cnt=%0d idle=%b in_ready=%b res_ready=%b out_valid=%b, required 0 1 1 1 0",
                     pk_cnt, idle, in_ready, res_ready, out_valid);
        end
        checks++;
        if (bpk !== 8'd0 || bup !== 8'd0 || blk_data !== 128'd0 || out_data !== 32'd0) begin
            errors++;
            $display("FAIL clear_data: bpk=%0d bup=%0d blk=%h out=%h, required 0 0 0 0", bpk, bup, blk_data, out_data);
        end
        for (int i = 0; i < 4; i++) begin
            in_valid_i = 1'b1;
            in_data_i  = w[i];
            tick();
        end
        in_valid_i = 1'b0;
        checks++;
        if (blk_valid !== 1'b1 || blk_data !== 128'h10101010_20202020_30303030_40404040) begin
            errors++;
            $display("FAIL clear_refill: blk_valid=%b blk=%h, required 1 10101010202020203030303040404040", blk_valid, blk_data);
        end
        tick();
        checks++;
        if (bpk !== 8'd1) begin
            errors++;
            $display("FAIL clear_refill_count: bpk=%0d, required 1", bpk);
        end
    endtask

    task automatic test_async_reset;
        blk_ready_i = 1'b1;
        in_valid_i = 1'b1; in_data_i = 32'h55550001; tick();
        in_data_i = 32'h55550002; tick();
        in_valid_i = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (pk_cnt !== 2'd0 || idle !== 1'b1 || bpk !== 8'd0 || blk_data !== 128'd0) begin
            errors++;
            $display("FAIL async_reset: pk_cnt=%0d idle=%b bpk=%0d blk=%h, required 0 1 0 0", pk_cnt, idle, bpk, blk_data);
        end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back;
        int in_sent, blk_got, res_sent, out_got, cyc;
        logic [127:0] eb, ebl;
        logic [31:0]  ew, ewl;
        in_sent = 0; blk_got = 0; res_sent = 0; out_got = 0;
        clear = 1'b1; tick(); clear = 1'b0;
        for (cyc = 0; cyc < 20000 && !(blk_got == 256 && out_got == 1024); cyc++) begin
            in_valid_i  = (in_sent < 1024) && (cyc % 3 != 2);
            in_data_i   = pword(in_sent);
            blk_ready_i = (cyc % 4 != 1);
            res_valid_i = (res_sent < 256) && (cyc % 5 != 3);
            res_data_i  = {rword(4*res_sent), rword(4*res_sent+1), rword(4*res_sent+2), rword(4*res_sent+3)};
            out_ready_i = (cyc % 3 != 0);
            if (in_valid_i && in_ready) in_sent++;
            if (blk_valid && blk_ready_i) begin
                eb  = {pword(4*blk_got), pword(4*blk_got+1), pword(4*blk_got+2), pword(4*blk_got+3)};
                ebl = {pword(4*blk_got+3), pword(4*blk_got+2), pword(4*blk_got+1), pword(4*blk_got)};
                checks++;
                if (blk_data !== eb || blk_data_l !== ebl) begin
                    errors++;
                    $display("FAIL stream_block_%0d: msb=%h lsb=%h, required %h %h", blk_got, blk_data, blk_data_l, eb, ebl);
                end
                blk_got++;
            end
            if (res_valid_i && res_ready) res_sent++;
            if (out_valid && out_ready_i) begin
                ew  = rword(out_got);
                ewl = rword(4*(out_got/4) + 3 - (out_got%4));
                checks++;
                if (out_data !== ew || out_data_l !== ewl) begin
                    errors++;
                    $display("FAIL stream_word_%0d: msb=%h lsb=%h, required %h %h", out_got, out_data, out_data_l, ew, ewl);
                end
                out_got++;
            end
            tick();
        end
        in_valid_i = 1'b0; res_valid_i = 1'b0; blk_ready_i = 1'b0; out_ready_i = 1'b0;
        checks++;
        if (blk_got != 256 || out_got != 1024 || in_sent != 1024 || res_sent != 256) begin
            errors++;
            $display("FAIL stream_totals: blocks=%0d words_out=%0d words_in=%0d res_in=%0d, required 256 1024 1024 256",
                     blk_got, out_got, in_sent, res_sent);
        end
        checks++;
        if (bpk !== 8'd0 || bup !== 8'd0 || bpk_l !== 8'd0 || bup_l !== 8'd0) begin
            errors++;
            $display("FAIL stream_wrap: bpk=%0d bup=%0d bpk_l=%0d bup_l=%0d, required 0 0 0 0", bpk, bup, bpk_l, bup_l);
        end
        tick();
        checks++;
        if (idle !== 1'b1 || idle_l !== 1'b1 || blk_valid !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stream_idle: idle=%b idle_l=%b blk_valid=%b out_valid=%b, required 1 1 0 0",
                     idle, idle_l, blk_valid, out_valid);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_pack();
        test_backpressure();
        test_unpack();
        test_clear();
        test_async_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_word_block_adapter.md
Name: aes_word_block_adapter

Overview:
- Datapath stage between the HWPE streamers and the AES core.
- Pack path: collects four 32-bit words from the plaintext source stream into one 128-bit block for the core.
- Unpack path: splits each 128-bit ciphertext block from the core into four 32-bit words for the ciphertext sink stream.
- Both paths use valid/ready handshakes. They are independent except for a shared clear and a shared idle status.

Parameters:
- MSB_FIRST, 1, word order. 1: word 0 maps to bits [127:96] and word 3 to [31:0]. 0: word 0 maps to [31:0].
- CNT_W, 8, width of the wrapping block counters.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous clear; highest priority after reset.
- in_data_i  in  32  plaintext word from the source stream.
- in_valid_i  in  1  plaintext word valid.
- in_ready_o  out  1  adapter accepts a plaintext word.
- blk_data_o  out  128  assembled plaintext block to the AES core.
- blk_valid_o  out  1  block valid.
- blk_ready_i  in  1  core accepts the block.
- res_data_i  in  128  ciphertext block from the core.
- res_valid_i  in  1  ciphertext valid.
- res_ready_o  out  1  adapter accepts a ciphertext block.
- out_data_o  out  32  ciphertext word to the sink stream.
- out_valid_o  out  1  ciphertext word valid.
- out_ready_i  in  1  sink accepts the word.
- pk_cnt_o  out  2  plaintext words held in the partial block.
- blocks_packed_o  out  CNT_W  blocks handed to the core.
- blocks_unpacked_o  out  CNT_W  blocks fully emitted to the sink.
- idle_o  out  1  both paths empty.

Behaviour:
- Reset: every register and output is 0, except idle_o=1 and the ready outputs, which are driven combinationally per state (in_ready_o=1, res_ready_o=1 when empty).
- A handshake occurs on a rising clk edge where valid=1 and ready=1.
- Pack FSM, states PK_FILL and PK_FULL:
  - in_ready_o = (state==PK_FILL). blk_valid_o = (state==PK_FULL).
  - On an input handshake in PK_FILL, in_data_i is written to slot pk_cnt and pk_cnt increments.
  - If pk_cnt==3 at that handshake: pk_cnt wraps to 0 and the next state is PK_FULL. blk_valid_o rises the cycle after the 4th word is accepted.
  - In PK_FULL, on blk_ready_i: blocks_packed_o+1 and return to PK_FILL. in_ready_o rises the following cycle.
  - No bypass, so minimum throughput is 5 cycles per block.
  - blk_data_o is stable while blk_valid_o=1 and blk_ready_i=0.
  - blk_data_o is the block register; slots not yet written in the current block hold their previous contents.
- Unpack FSM, states UP_EMPTY and UP_DRAIN:
  - res_ready_o = (state==UP_EMPTY). out_valid_o = (state==UP_DRAIN).
  - On a res handshake, res_data_i is captured, the word index is set to 0, and the next state is UP_DRAIN.
  - out_data_o is the captured slot[index], using the same MSB_FIRST mapping as the pack path.
  - Each out handshake increments the index. The handshake at index 3 also does blocks_unpacked_o+1 and returns to UP_EMPTY.
  - out_data_o and out_valid_o are held stable under backpressure.
- Counters wrap modulo 2^CNT_W with no saturation; 255+1 becomes 0 for CNT_W=8.
- idle_o = PK_FILL && pk_cnt==0 && UP_EMPTY, registered-state based with no added latency.
- clear:
  - Next cycle: both FSMs return to empty states, pk_cnt, index and both counters are 0, and data registers are 0.
  - clear overrides any handshake in the same cycle. Such a handshake is not counted and its data is discarded.
  - Upstream and downstream see ready high again one cycle after clear.
- Reset mid-operation: an asynchronous reset_n drop immediately forces the reset state, and partial blocks are lost.
- The two paths run concurrently. Simultaneous pack and unpack handshakes in one cycle are legal and independent.

Test Plan:
- MSB_FIRST=1, with blk_ready_i=1 held high (so the block is taken on its first valid cycle): feed 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF back-to-back -> blk_valid_o=1 exactly 1 cycle after the 4th accept, with blk_data_o=0x00112233_44556677_8899AABB_CCDDEEFF; blocks_packed_o=1; in_ready_o=0 only during that valid cycle.
- MSB_FIRST=0, same words -> blk_data_o=0xCCDDEEFF_8899AABB_44556677_00112233.
- Backpressure: hold blk_ready_i=0 for 10 cycles -> blk_data_o stable, in_ready_o=0, and extra in_valid_i words are not consumed (pk_cnt stays 0).
- Unpack: res_data_i=0x0123456789ABCDEF_FEDCBA9876543210, toggle out_ready_i every other cycle -> words 0x01234567, 0x89ABCDEF, 0xFEDCBA98, 0x76543210 in order, each stable while stalled; res_ready_o=1 the cycle after the 4th accept; blocks_unpacked_o=1.
- Clear during partial fill (pk_cnt=2) coinciding with an input handshake -> next cycle pk_cnt=0, idle_o=1, word not counted; a subsequent 4-word feed yields a block built only from the new words.
- Wrap and concurrency, CNT_W=8: 256 blocks through both paths simultaneously -> both counters read 0, with no lost or duplicated words checked by a scoreboard.
